add_pipe: RTL and testbench
===========================

// Module: add_pipe
// PURPOSE
//  Parametrised, pipelined ripple-carry adder: s = x + y + cy_in over WIDTH bits, split into
//  STAGES carry-chained chunks, one chunk per pipeline stage. Successor to the 4-bit add_4.
//  Sits in arithmetic datapaths that need wide adds at full clock rate with valid/ready flow
//  control. Throughput is one add per cycle; latency is STAGES cycles.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be >= 1
//  STAGES  4   pipeline stages; must divide WIDTH. Derived localparam CHUNK = WIDTH/STAGES
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      reset, asynchronous assert, active-low
//  in_valid   in   1      x, y, cy_in valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  x          in   WIDTH  operand A (unsigned; also read as two's complement for ovf)
//  y          in   WIDTH  operand B
//  cy_in      in   1      carry in
//  out_valid  out  1      s, cy_out, ovf valid
//  out_ready  in   1      downstream accepts result
//  s          out  WIDTH  sum, modulo 2^WIDTH
//  cy_out     out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (rst_n=0): all stage valid bits, s, cy_out, ovf go to 0 immediately. In-flight data
//    is discarded. in_ready=1 while in reset is not required; after release in_ready=1.
//  - Global advance: adv = !out_valid | out_ready; in_ready = adv (combinational).
//    All stage registers load only when adv=1; when adv=0, every stage holds.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Bubbles are not collapsed. A stage with valid=0 still moves forward when adv=1.
//  - Stage k (0..STAGES-1) adds chunk k of x and y, bits [k*CHUNK +: CHUNK], with the carry
//    registered from stage k-1. Stage 0 uses cy_in.
//  - Operand skew:
//      - Upper chunks not yet added travel in delay registers.
//      - Completed lower sum chunks travel forward alongside.
//  - Latency: a result accepted at edge n appears with out_valid=1 after edge n+STAGES-1
//    when adv stays 1. STAGES=1 gives a 1-cycle registered adder.
//  - Ordering is strict FIFO. No drop or duplicate under any out_ready pattern.
//  - While out_valid=1 & out_ready=0:
//      - s, cy_out, ovf are held stable.
//      - in_ready=0.
//  - Simultaneous out transfer and in transfer in the same cycle is legal (full throughput).
//  - Wrap-around: all-ones + 0 + cy_in=1 gives s=0, cy_out=1. No saturation.
//  - ovf is computed in the last stage from the MSB chunk carries. It is registered with s.
//  - in_valid=0 with adv=1 inserts a bubble. x, y, cy_in are don't-care then.
// STRUCTURE
//  - No shared package needed. WIDTH, STAGES and CHUNK are module parameters/localparams.
//  - Sub-module add_chunk #(CHUNK): combinational CHUNK-bit ripple adder
//      - inputs a, b, ci
//      - outputs sum, co, c_msb (carry into its MSB, used for ovf)
//  - Instantiate add_chunk STAGES times in a generate loop. Pipeline registers stay in add_pipe.
// TESTING
//  1. W16/S4: x=FFFF, y=0000, cy_in=1, out_ready=1 -> 4 cycles later s=0000, cy_out=1, ovf=0.
//  2. W16/S4: x=7FFF, y=0001, cy_in=0 -> s=8000, cy_out=0, ovf=1.
//     Then x=8000, y=8000 -> s=0000, cy_out=1, ovf=1.
//  3. 32 back-to-back random vectors, out_ready=1:
//     first result at cycle 4, one per cycle, in order, all match x+y+cy_in.
//  4. out_ready=0 for 5 cycles while out_valid=1:
//     s/cy_out/ovf constant, in_ready=0, then release; no loss or duplicate vs scoreboard.
//  5. rst_n pulsed low mid-stream with 3 results in flight:
//     out_valid=0 and s=0 before next edge; no stale result after release.
//  6. W4/S1 exhaustive over all 512 (x,y,cy_in) with random out_ready:
//     s/cy_out match add_4 golden, latency 1.

Source files
------------

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - combinational CHUNK-bit ripple adder slice
// Also exposes the carry into its MSB so the last slice can derive signed overflow.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined ripple-carry adder, one CHUNK-bit slice per stage
// Global-stall valid/ready pipeline: every stage loads together whenever the output can move.
module add_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cy_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cy_out,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_param
    $error("add_pipe: STAGES must divide WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] x_cur [STAGES];
  logic [WIDTH-1:0] y_cur [STAGES];
  logic [WIDTH-1:0] s_cur [STAGES];
  logic             c_cur [STAGES];
  logic             v_cur [STAGES];

  logic [WIDTH-1:0] x_d [STAGES];
  logic [WIDTH-1:0] y_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic [WIDTH-1:0] x_q [STAGES];
  logic [WIDTH-1:0] y_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [CHUNK-1:0] sum_w [STAGES];
  logic             co_w  [STAGES];
  logic             cm_w  [STAGES];

  logic ovf_d, ovf_q;

  assign out_valid = v_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign x_cur[k] = x;
      assign y_cur[k] = y;
      assign s_cur[k] = '0;
      assign c_cur[k] = cy_in;
      assign v_cur[k] = in_valid;
    end else begin : g_next
      assign x_cur[k] = x_q[k-1];
      assign y_cur[k] = y_q[k-1];
      assign s_cur[k] = s_q[k-1];
      assign c_cur[k] = c_q[k-1];
      assign v_cur[k] = v_q[k-1];
    end

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (x_cur[k][CHUNK-1:0]),
      .b     (y_cur[k][CHUNK-1:0]),
      .ci    (c_cur[k]),
      .sum   (sum_w[k]),
      .co    (co_w[k]),
      .c_msb (cm_w[k])
    );

    // Pending operand chunks shift down to bit 0; finished sum chunks enter at the top
    // and shift down, so chunk 0 lands at bit 0 after the last stage.
    assign x_d[k] = x_cur[k] >> CHUNK;
    assign y_d[k] = y_cur[k] >> CHUNK;
    assign s_d[k] = (s_cur[k] >> CHUNK) | (WIDTH'(sum_w[k]) << (WIDTH - CHUNK));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end else if (adv) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= co_w[k];
        v_q[k] <= v_cur[k];
      end
    end
  end

  assign ovf_d = cm_w[STAGES-1] ^ co_w[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign s      = s_q[STAGES-1];
  assign cy_out = c_q[STAGES-1];
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - self-checking bench for add_pipe (W16/S4 and W4/S1)
module tb_add_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit, 4-stage instance
  logic        a_iv, a_ir, a_ov, a_ordy, a_cin, a_cy, a_ovf;
  logic [15:0] a_x, a_y, a_s;
  // 4-bit, 1-stage instance
  logic        b_iv, b_ir, b_ov, b_ordy, b_cin, b_cy, b_ovf;
  logic [3:0]  b_x, b_y, b_s;

  add_pipe #(.WIDTH(16), .STAGES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .x(a_x), .y(a_y),
    .cy_in(a_cin), .out_valid(a_ov), .out_ready(a_ordy), .s(a_s), .cy_out(a_cy), .ovf(a_ovf)
  );

  add_pipe #(.WIDTH(4), .STAGES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .x(b_x), .y(b_y),
    .cy_in(b_cin), .out_valid(b_ov), .out_ready(b_ordy), .s(b_s), .cy_out(b_cy), .ovf(b_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int a_pops  = 0;
  int b_pops  = 0;
  bit a_lat   = 1'b0;
  bit b_lat   = 1'b0;
  bit b_rand  = 1'b0;

  logic [17:0] a_exp[$];
  logic [17:0] b_exp[$];
  int          a_acc[$];
  int          b_acc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Arithmetic reference: {ovf, carry, sum zero-extended to 16 bits}
  function automatic logic [17:0] ref_add(input int w, input longint unsigned xv,
                                          input longint unsigned yv, input longint unsigned cv);
    longint unsigned t, mask;
    logic sx, sy, ss, c, o;
    mask = (64'd1 << w) - 1;
    t    = xv + yv + cv;
    c    = t[w];
    sx   = xv[w-1];
    sy   = yv[w-1];
    ss   = t[w-1];
    o    = (sx == sy) && (ss != sx);
    return {o, c, 16'(t & mask)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_iv && a_ir) begin
        a_exp.push_back(ref_add(16, a_x, a_y, a_cin));
        a_acc.push_back(cyc);
      end
      if (a_ov && a_ordy) begin
        a_pops++;
        if (a_exp.size() == 0) check("a_unexpected_out", {a_ovf, a_cy, a_s}, 0);
        else begin
          check("a_result", {14'd0, a_ovf, a_cy, a_s}, {14'd0, a_exp.pop_front()});
          if (a_lat) check("a_latency", cyc - a_acc[0], 4);
          void'(a_acc.pop_front());
        end
      end
      if (b_iv && b_ir) begin
        b_exp.push_back(ref_add(4, b_x, b_y, b_cin));
        b_acc.push_back(cyc);
      end
      if (b_ov && b_ordy) begin
        b_pops++;
        if (b_exp.size() == 0) check("b_unexpected_out", {b_ovf, b_cy, b_s}, 0);
        else begin
          check("b_result", {14'd0, b_ovf, b_cy, 12'd0, b_s}, {14'd0, b_exp.pop_front()});
          if (b_lat) check("b_latency", cyc - b_acc[0], 1);
          void'(b_acc.pop_front());
        end
      end
    end
  end

  task automatic a_send(input logic [15:0] xv, input logic [15:0] yv, input logic cv);
    int k;
    a_x = xv; a_y = yv; a_cin = cv; a_iv = 1'b1;
    k = 0;
    @(negedge clk);
    while (!a_ir && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!a_ir) check("a_send_timeout", 0, 1);
    @(posedge clk); #1;
    a_iv = 1'b0;
  endtask

  task automatic b_send(input logic [3:0] xv, input logic [3:0] yv, input logic cv);
    int k;
    b_x = xv; b_y = yv; b_cin = cv; b_iv = 1'b1;
    k = 0;
    if (b_rand) b_ordy = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!b_ir && k < 100) begin
      @(posedge clk); #1;
      if (b_rand) b_ordy = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    if (!b_ir) check("b_send_timeout", 0, 1);
    @(posedge clk); #1;
    b_iv = 1'b0;
  endtask

  task automatic a_wait_out();
    int k = 0;
    @(negedge clk);
    while (!a_ov && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("a_out_valid_seen", a_ov, 1);
  endtask

  task automatic drain();
    int k = 0;
    a_ordy = 1'b1; b_ordy = 1'b1; b_rand = 1'b0;
    while ((a_exp.size() != 0 || b_exp.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("a_drained", a_exp.size(), 0);
    check("b_drained", b_exp.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] held_s;
    logic        held_c, held_o;
    int          p0;
    rst_n = 1'b0;
    a_iv = 0; a_x = 0; a_y = 0; a_cin = 0; a_ordy = 1;
    b_iv = 0; b_x = 0; b_y = 0; b_cin = 0; b_ordy = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_valid", a_ov, 0);
    check("rst_a_s", a_s, 0);
    check("rst_a_cy_ovf", {a_cy, a_ovf}, 0);
    check("rst_b_valid", b_ov, 0);
    rst_n = 1'b1;
    #1 check("post_rst_in_ready", {a_ir, b_ir}, 2'b11);
    @(posedge clk); #1;

    // wrap-around
    a_send(16'hFFFF, 16'h0000, 1'b1);
    a_wait_out();
    check("t1_s", a_s, 16'h0000);
    check("t1_cy_ovf", {a_cy, a_ovf}, 2'b10);
    @(posedge clk); #1;

    // signed overflow both directions
    a_send(16'h7FFF, 16'h0001, 1'b0);
    a_send(16'h8000, 16'h8000, 1'b0);
    a_wait_out();
    check("t2a_s", a_s, 16'h8000);
    check("t2a_cy_ovf", {a_cy, a_ovf}, 2'b01);
    @(negedge clk);
    check("t2b_valid", a_ov, 1);
    check("t2b_s", a_s, 16'h0000);
    check("t2b_cy_ovf", {a_cy, a_ovf}, 2'b11);
    drain();

    // back-to-back random stream, fixed latency
    p0 = a_pops;
    a_lat = 1'b1;
    for (int i = 0; i < 32; i++) a_send(16'($urandom), 16'($urandom), 1'($urandom));
    drain();
    a_lat = 1'b0;
    check("t3_count", a_pops - p0, 32);

    // output stall holds results and back-pressures input
    a_ordy = 1'b0;
    for (int i = 0; i < 4; i++) a_send(16'($urandom), 16'($urandom), 1'($urandom));
    @(negedge clk);
    check("t4_valid", a_ov, 1);
    held_s = a_s; held_c = a_cy; held_o = a_ovf;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_s", a_s, held_s);
      check("t4_hold_flags", {a_cy, a_ovf}, {held_c, held_o});
      check("t4_in_ready", a_ir, 0);
    end
    @(posedge clk); #1;
    drain();

    // reset mid-stream
    for (int i = 0; i < 3; i++) a_send(16'($urandom), 16'($urandom), 1'($urandom));
    #1 rst_n = 1'b0;
    #1;
    check("t5_valid", a_ov, 0);
    check("t5_s", a_s, 0);
    a_exp.delete(); a_acc.delete(); b_exp.delete(); b_acc.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_stale", a_ov, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) a_send(16'($urandom), 16'($urandom), 1'($urandom));
    drain();

    // 4-bit single-stage: latency, then exhaustive under random back-pressure
    b_lat = 1'b1;
    for (int i = 0; i < 8; i++) b_send(4'($urandom), 4'($urandom), 1'($urandom));
    drain();
    b_lat = 1'b0;
    p0 = b_pops;
    b_rand = 1'b1;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      b_send(v[3:0], v[7:4], v[8]);
    end
    drain();
    check("t6_count", b_pops - p0, 512);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
